// File: rtl/fp_stream_accumulator.sv
// Single-precision stream accumulator; optional saturation via FP_ACC_SATURATE_EN.
// Latency: operand accepted at edge E, sum register updated at E+3; one operand per 4 cycles.
// Backpressure: in_ready only in IDLE; final sum held in DONE until out_ready.
module fp_stream_accumulator #(
  parameter int LZC_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_FP_val,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum_FP_val,
  output logic        ovfl
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state;
  logic [31:0] acc;
  logic [31:0] op_r;
  logic        last_r;

  // align stage registers
  logic [7:0]  al_exp;
  logic [23:0] al_big_m;
  logic [23:0] al_sml_m;
  logic        al_big_s;
  logic        al_sml_s;

  // add stage registers
  logic [7:0]  ad_exp;
  logic [24:0] ad_sum;
  logic        ad_sgn;

  // align datapath
  logic [7:0]  acc_e, op_e, big_e, sml_e, diff;
  logic [23:0] acc_m, op_m, big_m, sml_m, sml_sh;
  logic        big_s, sml_s;

  always_comb begin
    acc_e = acc[30:23];
    op_e  = op_r[30:23];
    acc_m = (acc_e == 8'd0) ? 24'd0 : {1'b1, acc[22:0]};
    op_m  = (op_e == 8'd0) ? 24'd0 : {1'b1, op_r[22:0]};
    if (op_e > acc_e) begin
      big_e = op_e;  big_m = op_m;  big_s = op_r[31];
      sml_e = acc_e; sml_m = acc_m; sml_s = acc[31];
    end else begin
      big_e = acc_e; big_m = acc_m; big_s = acc[31];
      sml_e = op_e;  sml_m = op_m;  sml_s = op_r[31];
    end
    diff   = big_e - sml_e;
    sml_sh = sml_m;
    for (int i = 0; i < 5; i++) begin
      if (diff[i]) sml_sh = sml_sh >> (1 << i);
    end
    if (diff >= 8'd25) sml_sh = 24'd0;
  end

  // add datapath: magnitude compare decides sign on subtraction
  logic [24:0] sum_c;
  logic        sgn_c;

  always_comb begin
    if (al_big_s == al_sml_s) begin
      sum_c = {1'b0, al_big_m} + {1'b0, al_sml_m};
      sgn_c = al_big_s;
    end else if (al_big_m >= al_sml_m) begin
      sum_c = {1'b0, al_big_m} - {1'b0, al_sml_m};
      sgn_c = al_big_s;
    end else begin
      sum_c = {1'b0, al_sml_m} - {1'b0, al_big_m};
      sgn_c = al_sml_s;
    end
    if (sum_c == 25'd0) sgn_c = 1'b0;
  end

  // normalize datapath
  logic [LZC_W-1:0] lzc;
  logic             found;
  logic [9:0]       exp_n;
  logic [22:0]      frac_n;
  logic             exp_le0, exp_ovf;
  logic [31:0]      res;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (ad_sum[i]) found = 1'b1;
        else           lzc   = lzc + LZC_W'(1);
      end
    end
    if (ad_sum[24]) begin
      frac_n = ad_sum[23:1];
      exp_n  = {2'b00, ad_exp} + 10'd1;
    end else begin
      frac_n = ad_sum[22:0] << lzc;
      exp_n  = {2'b00, ad_exp} - {{(10-LZC_W){1'b0}}, lzc};
    end
    exp_le0 = exp_n[9] || (exp_n == 10'd0);
    exp_ovf = !exp_n[9] && (exp_n >= 10'd255);
    if (ad_sum == 25'd0 || exp_le0)
      res = 32'h0000_0000;
    else if (exp_ovf)
`ifdef FP_ACC_SATURATE_EN
      res = {ad_sgn, 8'hFE, 23'h7F_FFFF};
`else
      res = {ad_sgn, 8'hFF, 23'h00_0000};
`endif
    else
      res = {ad_sgn, exp_n[7:0], frac_n};
  end

`ifdef FP_ACC_SATURATE_EN
  logic ovfl_r;
  assign ovfl = ovfl_r;
`else
  assign ovfl = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state      <= IDLE;
      acc        <= 32'h0000_0000;
      op_r       <= 32'h0000_0000;
      last_r     <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      sum_FP_val <= 32'h0000_0000;
      al_exp     <= 8'd0;
      al_big_m   <= 24'd0;
      al_sml_m   <= 24'd0;
      al_big_s   <= 1'b0;
      al_sml_s   <= 1'b0;
      ad_exp     <= 8'd0;
      ad_sum     <= 25'd0;
      ad_sgn     <= 1'b0;
`ifdef FP_ACC_SATURATE_EN
      ovfl_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r     <= in_FP_val;
            last_r   <= in_last;
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          al_exp   <= big_e;
          al_big_m <= big_m;
          al_sml_m <= sml_sh;
          al_big_s <= big_s;
          al_sml_s <= sml_s;
          state    <= ADD;
        end
        ADD: begin
          ad_exp <= al_exp;
          ad_sum <= sum_c;
          ad_sgn <= sgn_c;
          state  <= NORM;
        end
        NORM: begin
          acc <= res;
`ifdef FP_ACC_SATURATE_EN
          if (ad_sum != 25'd0 && !exp_le0 && exp_ovf) ovfl_r <= 1'b1;
`endif
          if (last_r) begin
            out_valid  <= 1'b1;
            sum_FP_val <= res;
            state      <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= 32'h0000_0000;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed and randomized checks for fp_stream_accumulator; honours FP_ACC_SATURATE_EN.
module tb_fp_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, in_last, out_valid, out_ready, ovfl;
  logic [31:0] in_FP_val, sum_FP_val;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fp_stream_accumulator #(.LZC_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_FP_val  (in_FP_val),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_FP_val (sum_FP_val),
    .ovfl       (ovfl)
  );

  function automatic real pow2(input int e);
    real v;
    v = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) v = v * 2.0;
    else        for (int i = 0; i < -e; i++) v = v / 2.0;
    return v;
  endfunction

  function automatic real fp2real(input logic [31:0] f);
    real v;
    if (f[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
    return f[31] ? -v : v;
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic push(input logic [31:0] v, input logic last);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_ready in_ready=%b required 1", in_ready);
    end
    in_valid  = 1'b1;
    in_FP_val = v;
    in_last   = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] s);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout out_valid=%b required 1", out_valid);
    end
    s = sum_FP_val;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b req=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b req=0", out_valid); end
    checks++; if (sum_FP_val !== 32'h0) begin errors++; $display("FAIL reset_sum got=%h req=0", sum_FP_val); end
    checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL reset_ovfl got=%b req=0", ovfl); end
  endtask

  task automatic test_basic();
    logic [31:0] ops [3];
    ops[0] = 32'h3F80_0000;
    ops[1] = 32'h4000_0000;
    ops[2] = 32'h4040_0000;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(ops[k], k == 2);
      for (int c = 0; c < 3; c++) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy op%0d cyc%0d in_ready=%b req=0", k, c, in_ready); end
        if (c == 2 && k == 2) begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early out_valid=%b req=0", out_valid); end
        end
        @(negedge clk);
      end
      if (k < 2) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready op%0d in_ready=%b req=1", k, in_ready); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid out_valid=%b req=1", out_valid); end
        checks++; if (sum_FP_val !== 32'h40C0_0000) begin errors++; $display("FAIL basic_sum got=%h req=40c00000", sum_FP_val); end
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_after out_valid=%b in_ready=%b req 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_cancel();
    logic [31:0] s;
    push(32'h40A0_0000, 1'b0);
    push(32'hC0A0_0000, 1'b1);
    wait_result(s);
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL cancel_sum got=%h req=00000000", s); end
    take();
  endtask

  task automatic test_truncate();
    logic [31:0] s;
    push(32'h4E80_0000, 1'b0);
    push(32'h3F80_0000, 1'b1);
    wait_result(s);
    checks++; if (s !== 32'h4E80_0000) begin errors++; $display("FAIL trunc_sum got=%h req=4e800000", s); end
    take();
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    push(32'h7F7F_FFFF, 1'b0);
    push(32'h7F7F_FFFF, 1'b1);
    wait_result(s);
`ifdef FP_ACC_SATURATE_EN
    checks++; if (s !== 32'h7F7F_FFFF) begin errors++; $display("FAIL ovf_sum got=%h req=7f7fffff", s); end
    checks++; if (ovfl !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b req=1", ovfl); end
    take();
    checks++; if (ovfl !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b req=1", ovfl); end
`else
    checks++; if (s !== 32'h7F80_0000) begin errors++; $display("FAIL ovf_sum got=%h req=7f800000", s); end
    checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL ovf_flag got=%b req=0", ovfl); end
    take();
`endif
  endtask

  task automatic test_hold();
    logic [31:0] s;
    push(32'hC228_0000, 1'b1);
    wait_result(s);
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc%0d got=%b req=1", c, out_valid); end
      checks++; if (sum_FP_val !== 32'hC228_0000) begin errors++; $display("FAIL hold_sum cyc%0d got=%h req=c2280000", c, sum_FP_val); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready cyc%0d got=%b req=0", c, in_ready); end
      @(negedge clk);
    end
    take();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release out_valid=%b in_ready=%b req 0/1", out_valid, in_ready);
    end
    push(32'h3F80_0000, 1'b1);
    wait_result(s);
    checks++; if (s !== 32'h3F80_0000) begin errors++; $display("FAIL hold_cleared got=%h req=3f800000", s); end
    take();
  endtask

  task automatic test_abort(input logic use_clr);
    logic [31:0] s;
    push(32'h3F80_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    push(32'h4080_0000, 1'b1);
    @(negedge clk);
    if (use_clr) clr = 1'b1;
    else         rst_n = 1'b0;
    @(negedge clk);
    clr   = 1'b0;
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort%0d_state in_ready=%b out_valid=%b req 1/0", use_clr, in_ready, out_valid);
    end
    checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL abort%0d_ovfl got=%b req=0", use_clr, ovfl); end
    push(32'h3F80_0000, 1'b1);
    wait_result(s);
    checks++; if (s !== 32'h3F80_0000) begin errors++; $display("FAIL abort%0d_sum got=%h req=3f800000", use_clr, s); end
    take();
  endtask

  task automatic test_random();
    int done;
    int stream;
    done   = 0;
    stream = 0;
    while (done < 1000) begin
      int          len;
      int          maxe;
      real         rsum, tol, d;
      logic [31:0] op, got;
      len = $urandom_range(1, 16);
      if (len > 1000 - done) len = 1000 - done;
      rsum = 0.0;
      maxe = 0;
      for (int i = 0; i < len; i++) begin
        op = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
        rsum = rsum + fp2real(op);
        if (int'(op[30:23]) > maxe) maxe = int'(op[30:23]);
        push(op, i == len - 1);
      end
      wait_result(got);
      take();
      // truncation loses under 2 ulp of the largest partial sum per step
      tol = 2.0 * real'(len) * pow2(maxe - 127 + 5 - 23);
      d = fp2real(got) - rsum;
      if (d < 0.0) d = -d;
      checks++; if (d > tol) begin
        errors++; $display("FAIL random_stream%0d got=%h (%g) ref=%g tol=%g", stream, got, fp2real(got), rsum, tol);
      end
      done += len;
      stream++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_FP_val = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_cancel();
    test_truncate();
    test_overflow();
    test_hold();
    test_abort(1'b1);
    test_overflow();
    test_abort(1'b0);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
